regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_scoreboard.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-bank writeback arbiter and its scoreboard.
// Optional forwarding path in the top level is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    function automatic wb_req_t select_req(input wb_src_e src, input wb_req_t req_a, input wb_req_t req_b);
        return (src == SRC_ALU) ? req_a : req_b;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for long-latency destinations; a set beats a clear of the same
// register on the same edge, and register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    input  logic [REG_AW-1:0] q_rd,
    output logic              busy_hit
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    always_comb begin
        // NOTE: start from the held value so every path assigns busy_next and no latch is inferred.
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: the busy vector is a small flop array, so it is reset; a stale bit would stall decode forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_hit = busy[q_rs1] | busy[q_rs2] | busy[q_rd];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and LSU writeback onto the single register-bank write port,
// with busy scoreboard for decode hazards. Define REGFILE_BYPASS_EN to enable the forwarding path.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_data,
    input  logic              sb_set,
    input  logic [REG_AW-1:0] sb_rd,
    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    input  logic [REG_AW-1:0] q_rd,
    output logic              hazard,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_rd,
    output logic [XLEN-1:0]   wr_data,
    output logic              fwd_rs1_hit,
    output logic              fwd_rs2_hit,
    output logic [XLEN-1:0]   fwd_rs1_data,
    output logic [XLEN-1:0]   fwd_rs2_data
);

    wb_req_t req_a;
    wb_req_t req_b;
    wb_req_t gnt_req;
    wb_src_e gnt_src;
    logic    prefer_a;
    logic    conflict;
    logic    gnt_write;
    logic    busy_hit;
    logic    inflight;

    assign req_a = '{valid: a_valid, rd: a_rd, data: a_data};
    assign req_b = '{valid: b_valid, rd: b_rd, data: b_data};

    assign a_ready  = !b_valid | prefer_a;
    assign b_ready  = !a_valid | !prefer_a;
    assign conflict = a_valid & b_valid;

    // Whenever A is not granted, B is either granted or idle, so gnt_req.valid is the grant.
    assign gnt_src   = (a_valid & a_ready) ? SRC_ALU : SRC_LSU;
    assign gnt_req   = select_req(gnt_src, req_a, req_b);
    assign gnt_write = gnt_req.valid & (gnt_req.rd != '0);

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_a <= 1'b0;
        end else if (conflict) begin
            prefer_a <= (gnt_src == SRC_LSU);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else if (gnt_req.valid) begin
            wr_en   <= gnt_write;
            wr_rd   <= gnt_req.rd;
            wr_data <= gnt_req.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set & (sb_rd != '0)),
        .set_rd   (sb_rd),
        .clr_en   (gnt_write),
        .clr_rd   (gnt_req.rd),
        .q_rs1    (q_rs1),
        .q_rs2    (q_rs2),
        .q_rd     (q_rd),
        .busy_hit (busy_hit)
    );

`ifdef REGFILE_BYPASS_EN
    // Reads of the register being written are served by the bypass; only WAW must stall.
    assign fwd_rs1_hit  = wr_en & (wr_rd == q_rs1);
    assign fwd_rs2_hit  = wr_en & (wr_rd == q_rs2);
    assign fwd_rs1_data = wr_data;
    assign fwd_rs2_data = wr_data;
    assign inflight     = wr_en & (wr_rd == q_rd);
`else
    assign fwd_rs1_hit  = 1'b0;
    assign fwd_rs2_hit  = 1'b0;
    assign fwd_rs1_data = '0;
    assign fwd_rs2_data = '0;
    assign inflight     = wr_en & ((wr_rd == q_rs1) | (wr_rd == q_rs2) | (wr_rd == q_rd));
`endif

    assign hazard = busy_hit | inflight;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a behavioural model. Honours REGFILE_BYPASS_EN if defined.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              a_valid, b_valid, sb_set;
    logic              a_ready, b_ready, hazard, wr_en;
    logic [REG_AW-1:0] a_rd, b_rd, sb_rd, q_rs1, q_rs2, q_rd, wr_rd;
    logic [XLEN-1:0]   a_data, b_data, wr_data;
    logic              fwd_rs1_hit, fwd_rs2_hit;
    logic [XLEN-1:0]   fwd_rs1_data, fwd_rs2_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .sb_set       (sb_set),
        .sb_rd        (sb_rd),
        .q_rs1        (q_rs1),
        .q_rs2        (q_rs2),
        .q_rd         (q_rd),
        .hazard       (hazard),
        .wr_en        (wr_en),
        .wr_rd        (wr_rd),
        .wr_data      (wr_data),
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_data (fwd_rs2_data)
    );

    typedef struct {
        logic              a_valid;
        logic [REG_AW-1:0] a_rd;
        logic [XLEN-1:0]   a_data;
        logic              b_valid;
        logic [REG_AW-1:0] b_rd;
        logic [XLEN-1:0]   b_data;
        logic              sb_set;
        logic [REG_AW-1:0] sb_rd;
        logic [REG_AW-1:0] q_rs1;
        logic [REG_AW-1:0] q_rs2;
        logic [REG_AW-1:0] q_rd;
    } stim_t;

    typedef struct {
        stim_t             s;
        logic              exp_a_ready;
        logic              exp_b_ready;
        logic              exp_hazard;
        logic              exp_wr_en;
        logic [REG_AW-1:0] exp_wr_rd;
        logic [XLEN-1:0]   exp_wr_data;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: busy set, pending bank write, and number of conflicts arbitrated so far.
    bit                m_busy [NREG];
    logic              m_wr_en;
    logic [REG_AW-1:0] m_wr_rd;
    logic [XLEN-1:0]   m_wr_data;
    int                m_conf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{a_valid: 1'b0, a_rd: '0, a_data: '0, b_valid: 1'b0, b_rd: '0, b_data: '0,
              sb_set: 1'b0, sb_rd: '0, q_rs1: '0, q_rs2: '0, q_rd: '0};
        return s;
    endfunction

    function automatic vec_t mkv(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                                 input logic ear, input logic ebr, input logic ewe,
                                 input logic [4:0] erd, input logic [31:0] ed);
        vec_t v;
        v.s = idle();
        v.s.a_valid = av; v.s.a_rd = ard; v.s.a_data = ad;
        v.s.b_valid = bv; v.s.b_rd = brd; v.s.b_data = bd;
        v.exp_a_ready = ear; v.exp_b_ready = ebr; v.exp_hazard = 1'b0;
        v.exp_wr_en = ewe; v.exp_wr_rd = erd; v.exp_wr_data = ed;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        a_valid = s.a_valid; a_rd = s.a_rd; a_data = s.a_data;
        b_valid = s.b_valid; b_rd = s.b_rd; b_data = s.b_data;
        sb_set = s.sb_set; sb_rd = s.sb_rd;
        q_rs1 = s.q_rs1; q_rs2 = s.q_rs2; q_rd = s.q_rd;
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wr_en = 1'b0; m_wr_rd = '0; m_wr_data = '0; m_conf = 0;
    endtask

    // Applies the arbitration rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit                gnt;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   d;
        gnt = 1'b1; rd = '0; d = '0;
        if (a_valid && b_valid) begin
            if (m_conf % 2 == 0) begin rd = b_rd; d = b_data; end
            else                 begin rd = a_rd; d = a_data; end
            m_conf++;
        end else if (a_valid) begin
            rd = a_rd; d = a_data;
        end else if (b_valid) begin
            rd = b_rd; d = b_data;
        end else begin
            gnt = 1'b0;
        end
        if (gnt) begin
            m_wr_en = (rd != 0); m_wr_rd = rd; m_wr_data = d;
            if (rd != 0) m_busy[rd] = 1'b0;
        end else begin
            m_wr_en = 1'b0;
        end
        if (sb_set && sb_rd != 0) m_busy[sb_rd] = 1'b1;
    endtask

    function automatic logic model_hazard();
        logic busy_any, infl;
        busy_any = m_busy[q_rs1] | m_busy[q_rs2] | m_busy[q_rd];
        if (BYP) infl = m_wr_en && (m_wr_rd == q_rd);
        else     infl = m_wr_en && (m_wr_rd == q_rs1 || m_wr_rd == q_rs2 || m_wr_rd == q_rd);
        return busy_any | infl;
    endfunction

    task automatic check_comb_model(input string tag);
        check({tag, "_a_ready"}, 32'(a_ready), 32'(!b_valid || (m_conf % 2 == 1)));
        check({tag, "_b_ready"}, 32'(b_ready), 32'(!a_valid || (m_conf % 2 == 0)));
        check({tag, "_hazard"},  32'(hazard),  32'(model_hazard()));
        check({tag, "_fwd1_hit"}, 32'(fwd_rs1_hit), 32'(BYP && m_wr_en && m_wr_rd == q_rs1));
        check({tag, "_fwd2_hit"}, 32'(fwd_rs2_hit), 32'(BYP && m_wr_en && m_wr_rd == q_rs2));
        check({tag, "_fwd1_data"}, fwd_rs1_data, BYP ? m_wr_data : 32'h0);
        check({tag, "_fwd2_data"}, fwd_rs2_data, BYP ? m_wr_data : 32'h0);
    endtask

    task automatic check_reg_model(input string tag);
        check({tag, "_wr_en"},   32'(wr_en), 32'(m_wr_en));
        check({tag, "_wr_rd"},   32'(wr_rd), 32'(m_wr_rd));
        check({tag, "_wr_data"}, wr_data,    m_wr_data);
    endtask

    // One cycle: drive after the falling edge, check combinational outputs, then registered ones.
    task automatic cycle(input stim_t s, input string tag);
        @(negedge clk);
        drive(s);
        #1;
        check_comb_model(tag);
        @(posedge clk);
        model_edge();
        #1;
        check_reg_model(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  tbl [9];
        stim_t s;

        tbl[0] = mkv(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 1, 1, 5, 32'hDEADBEEF);
        tbl[1] = mkv(0, 0, 0,            0, 0, 0,            1, 1, 0, 5, 32'hDEADBEEF);
        tbl[2] = mkv(1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 2, 32'h22);
        tbl[3] = mkv(1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 1, 1, 32'h11);
        tbl[4] = mkv(1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 2, 32'h22);
        tbl[5] = mkv(1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 1, 1, 32'h11);
        tbl[6] = mkv(0, 0, 0,            1, 0, 32'h33,       0, 1, 0, 0, 32'h33);
        tbl[7] = mkv(0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 32'h33);
        tbl[8] = mkv(1, 0, 32'h44,       0, 0, 0,            1, 1, 0, 0, 32'h44);

        model_reset();
        drive(idle());
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_wr_en",   32'(wr_en), 32'h0);
        check("reset_wr_rd",   32'(wr_rd), 32'h0);
        check("reset_wr_data", wr_data,    32'h0);
        check("reset_hazard",  32'(hazard), 32'h0);
        check("reset_fwd1",    32'(fwd_rs1_hit), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i].s);
            #1;
            check($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].exp_a_ready));
            check($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].exp_b_ready));
            check($sformatf("vec%0d_hazard", i),  32'(hazard),  32'(tbl[i].exp_hazard));
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d_wr_en", i),   32'(wr_en), 32'(tbl[i].exp_wr_en));
            check($sformatf("vec%0d_wr_rd", i),   32'(wr_rd), 32'(tbl[i].exp_wr_rd));
            check($sformatf("vec%0d_wr_data", i), wr_data,    tbl[i].exp_wr_data);
        end

        // Long-latency writer to x7 stalls a reader until its writeback drains.
        s = idle(); s.sb_set = 1'b1; s.sb_rd = 7;
        cycle(s, "sb7_set");
        s = idle(); s.q_rs1 = 7;
        cycle(s, "sb7_wait");
        check("sb7_busy_hazard", 32'(hazard), 32'h1);
        s.b_valid = 1'b1; s.b_rd = 7; s.b_data = 32'h7777_0007;
        cycle(s, "sb7_grant");
        check("sb7_hazard_grant+1", 32'(hazard), BYP ? 32'h0 : 32'h1);
        check("sb7_fwd_hit_grant+1", 32'(fwd_rs1_hit), BYP ? 32'h1 : 32'h0);
        s = idle(); s.q_rs1 = 7;
        cycle(s, "sb7_drain");
        check("sb7_hazard_grant+2", 32'(hazard), 32'h0);

        // Set and clear of x9 on the same edge: the set must win.
        s = idle(); s.sb_set = 1'b1; s.sb_rd = 9; s.b_valid = 1'b1; s.b_rd = 9; s.b_data = 32'h99;
        cycle(s, "sb9_setclr");
        s = idle(); s.q_rs2 = 9;
        cycle(s, "sb9_idle");
        check("sb9_still_busy", 32'(hazard), 32'h1);
        s.a_valid = 1'b1; s.a_rd = 9; s.a_data = 32'h9999;
        cycle(s, "sb9_clear");
        s = idle(); s.q_rs2 = 9;
        cycle(s, "sb9_drain");
        check("sb9_cleared", 32'(hazard), 32'h0);

        // Mid-transfer reset drops the registered write and the scoreboard.
        s = idle(); s.sb_set = 1'b1; s.sb_rd = 12;
        cycle(s, "rst_set12");
        s = idle(); s.a_valid = 1'b1; s.a_rd = 3; s.a_data = 32'h3333; s.q_rs1 = 3; s.q_rd = 12;
        cycle(s, "rst_write3");
        check("rst_pre_wr_en", 32'(wr_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_wr_en",     32'(wr_en), 32'h0);
        check("rst_wr_data",   wr_data,    32'h0);
        check("rst_hazard",    32'(hazard), 32'h0);
        check("rst_fwd1_hit",  32'(fwd_rs1_hit), 32'h0);
        check("rst_fwd1_data", fwd_rs1_data, 32'h0);
        @(negedge clk);
        drive(idle());
        rst_n = 1'b1;
        s = idle(); s.a_valid = 1'b1; s.a_rd = 4; s.a_data = 32'hA4; s.b_valid = 1'b1; s.b_rd = 6; s.b_data = 32'hB6;
        cycle(s, "rst_conflict");
        check("rst_b_wins_rd", 32'(wr_rd), 32'h6);

        // Randomized traffic against the model; decode never re-marks a busy register.
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.a_valid = 1'($urandom_range(0, 1));
            s.a_rd    = 5'($urandom_range(0, 7));
            s.a_data  = $urandom;
            s.b_valid = 1'($urandom_range(0, 1));
            s.b_rd    = 5'($urandom_range(0, 7));
            s.b_data  = $urandom;
            s.sb_rd   = 5'($urandom_range(0, 7));
            s.sb_set  = ($urandom_range(0, 3) == 0) && !m_busy[s.sb_rd];
            s.q_rs1   = 5'($urandom_range(0, 7));
            s.q_rs2   = 5'($urandom_range(0, 7));
            s.q_rd    = 5'($urandom_range(0, 7));
            cycle(s, $sformatf("rnd%0d", i));
        end

        drive(idle());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
